// File: rtl/alu4_arb_pkg.sv
// Shared constants and types for the two-requester 4-bit ALU arbiter.
// Optional feature macro: ALU4_ARB_ZERO_FLAG_EN (adds a registered zero flag).
package alu4_arb_pkg;

    // Operand / result width; the datapath is built for exactly 4 bits.
    localparam int W = 4;

    // ALU opcodes as presented on reqN_op.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Arbiter/sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: per-bit AND/OR/XOR gate banks plus a ripple-carry
// adder sharing the XOR/AND banks as propagate/generate terms.
module alu4_core
    import alu4_arb_pkg::*;
(
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] data,
    output logic         cout
);

    logic [W-1:0] and_bits;
    logic [W-1:0] or_bits;
    logic [W-1:0] xor_bits;
    logic [W-1:0] sum_bits;
    logic [W:0]   carry;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign and_bits[i] = a[i] & b[i];
            assign or_bits[i]  = a[i] | b[i];
            assign xor_bits[i] = a[i] ^ b[i];
            assign sum_bits[i] = xor_bits[i] ^ carry[i];
            assign carry[i+1]  = and_bits[i] | (xor_bits[i] & carry[i]);
        end
    endgenerate

    // Select the bank for the opcode; carry-out only has meaning for ADD.
    always_comb begin
        data = '0;
        cout = 1'b0;
        case (op)
            OP_AND: data = and_bits;
            OP_OR:  data = or_bits;
            OP_XOR: data = xor_bits;
            OP_ADD: begin
                data = sum_bits;
                cout = carry[W];
            end
            default: begin
                data = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; reqN_ready is combinational and only high in IDLE for the granted
// requester, rsp_valid is registered and the response is held until rsp_ready.
// Optional feature macro: ALU4_ARB_ZERO_FLAG_EN adds rsp_zero (result == 0).
module alu4_arbiter
    import alu4_arb_pkg::*;
#(
    parameter logic RST_GRANT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_cout,
`ifdef ALU4_ARB_ZERO_FLAG_EN
    output logic         rsp_zero,
`endif
    output logic [1:0]   dbg_state
);

    state_t       state;
    logic         last_grant;
    logic         grant;
    logic         accept;
    logic [1:0]   lat_op;
    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    logic         lat_id;
    logic [W-1:0] alu_data;
    logic         alu_cout;

    assign dbg_state = state;

    // Pick the requester: a lone valid wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Readies are gated by reset so every output reads 0 while rst_n is low.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    alu4_core u_core (
        .op   (lat_op),
        .a    (lat_a),
        .b    (lat_b),
        .data (alu_data),
        .cout (alu_cout)
    );

    // Sequencer: latch the granted operation, evaluate for one cycle, then hold
    // the tagged result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= RST_GRANT;
            lat_op     <= OP_AND;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
`ifdef ALU4_ARB_ZERO_FLAG_EN
            rsp_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_op <= grant ? req1_op : req0_op;
                        lat_a  <= grant ? req1_a  : req0_a;
                        lat_b  <= grant ? req1_b  : req0_b;
                        lat_id <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_data;
                    rsp_cout  <= alu_cout;
                    rsp_id    <= lat_id;
`ifdef ALU4_ARB_ZERO_FLAG_EN
                    rsp_zero  <= (alu_data == '0);
`endif
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter: vector table, random ops, fairness,
// backpressure and reset-in-RESP sequences; responses checked via exp_q.
// Optional feature macro: ALU4_ARB_ZERO_FLAG_EN (also checks rsp_zero).
module tb_alu4_arbiter;
    import alu4_arb_pkg::*;

`ifdef ALU4_ARB_ZERO_FLAG_EN
    localparam int EW = 7;
`else
    localparam int EW = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [3:0] req0_a = 4'h0, req0_b = 4'h0, req1_a = 4'h0, req1_b = 4'h0;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic       rsp_id, rsp_cout;
    logic [3:0] rsp_data;
    logic [1:0] dbg_state;
`ifdef ALU4_ARB_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic       cout;
        logic       zero;
    } vec_t;

    vec_t tbl[10];

    alu4_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
`ifdef ALU4_ARB_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a ^ b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    function automatic logic [EW-1:0] pack(input logic id, input logic cout, input logic [3:0] data, input logic zero);
`ifdef ALU4_ARB_ZERO_FLAG_EN
        return {zero, id, cout, data};
`else
        return {id, cout, data};
`endif
    endfunction

    task automatic drive_req(input logic id, input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Issue one op, push its expected response, check the T+1 / T+2 latency.
    // Ends at the falling edge of the first RESP cycle.
    task automatic issue(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] data, input logic cout, input logic zero);
        int n = 0;
        logic rdy;
        @(posedge clk); #1;
        drive_req(id, 1'b1, op, a, b);
        do begin
            @(negedge clk);
            n++;
            rdy = id ? req1_ready : req0_ready;
        end while (!rdy && n < 20);
        check("accept", 32'(rdy), 32'd1);
        exp_q.push_back(pack(id, cout, data, zero));
        @(posedge clk); #1;
        drive_req(id, 1'b0, 2'b00, 4'h0, 4'h0);
        @(negedge clk);
        check("lat_exec_valid", 32'(rsp_valid), 32'd0);
        check("exec_no_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and one-ready monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready)
                check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
`ifdef ALU4_ARB_ZERO_FLAG_EN
                    check("rsp", 32'({rsp_zero, rsp_id, rsp_cout, rsp_data}), 32'(exp_q.pop_front()));
`else
                    check("rsp", 32'({rsp_id, rsp_cout, rsp_data}), 32'(exp_q.pop_front()));
`endif
                end
            end
        end
    end

    initial begin
        int n;
        int cyc;
        int gcyc[6];
        logic order[6];
        logic [4:0] res;
        logic id;
        logic [1:0] op;
        logic [3:0] a, b;

        tbl[0] = '{1'b0, OP_ADD, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, OP_XOR, 4'hA, 4'hF, 4'h5, 1'b0, 1'b0};
        tbl[2] = '{1'b1, OP_AND, 4'hA, 4'h6, 4'h2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, OP_OR,  4'hA, 4'h5, 4'hF, 1'b0, 1'b0};
        tbl[4] = '{1'b0, OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, OP_ADD, 4'h7, 4'h8, 4'hF, 1'b0, 1'b0};
        tbl[6] = '{1'b1, OP_ADD, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0};
        tbl[7] = '{1'b0, OP_XOR, 4'h7, 4'h7, 4'h0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, OP_AND, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[9] = '{1'b1, OP_ADD, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};

        // Reset with both requesters pushing: every output must stay 0.
        drive_req(1'b0, 1'b1, OP_ADD, 4'h3, 4'h3);
        drive_req(1'b1, 1'b1, OP_OR, 4'h3, 4'h3);
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef ALU4_ARB_ZERO_FLAG_EN
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
`endif
        drive_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        drive_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++)
            issue(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].data, tbl[i].cout, tbl[i].zero);

        // Random ops against the reference model
        for (int i = 0; i < 8; i++) begin
            id = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            res = model(op, a, b);
            issue(id, op, a, b, res[3:0], res[4], res[3:0] == 4'h0);
        end

        // Serve requester 1 last so the first tie must go to requester 0.
        issue(1'b1, OP_OR, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0);
        wait_drain("pre_fair_drain");

        // Fairness: both requesters hold valid for six grants.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, OP_ADD, 4'h3, 4'h4);
        drive_req(1'b1, 1'b1, OP_XOR, 4'h5, 4'hC);
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req0_ready) begin
                exp_q.push_back(pack(1'b0, 1'b0, 4'h7, 1'b0));
                order[n] = 1'b0; gcyc[n] = cyc; n++;
            end else if (req1_ready) begin
                exp_q.push_back(pack(1'b1, 1'b0, 4'h9, 1'b0));
                order[n] = 1'b1; gcyc[n] = cyc; n++;
            end
        end
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        drive_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        check("fair_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < n) check("fair_order", 32'(order[i]), 32'(i % 2));
        for (int i = 1; i < 6; i++)
            if (i < n) check("issue_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        wait_drain("fair_drain");

        // Backpressure: response held five cycles while requester 1 waits.
        rsp_ready = 1'b0;
        issue(1'b0, OP_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, OP_ADD, 4'h1, 4'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold", 32'({rsp_id, rsp_cout, rsp_data}), 32'h08);
            check("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_state", 32'(dbg_state), 32'(IDLE));
        wait_drain("bp_drain");

        // Reset mid-RESP: last served was requester 0, yet the reset
        // restores the default so the next tie still goes to requester 0.
        rsp_ready = 1'b0;
        issue(1'b0, OP_OR, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        drive_req(1'b0, 1'b1, OP_ADD, 4'h2, 4'h3);
        drive_req(1'b1, 1'b1, OP_XOR, 4'h6, 4'h3);
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_mid_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_tie_grant", 32'({req1_ready, req0_ready}), 32'b01);
        if (req0_ready) exp_q.push_back(pack(1'b0, 1'b0, 4'h5, 1'b0));
        if (req1_ready) exp_q.push_back(pack(1'b1, 1'b0, 4'h5, 1'b0));
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
        drive_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
        wait_drain("final_drain");
        repeat (3) @(negedge clk);
        check("idle_no_rsp", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
